// File: rtl/bonus_effect_ctrl_if.sv
// Purpose : bundles the bonus-effect controller's game-side signals.
// Ports   : bonus_code/startOfFrame/clear_effects toward the controller;
//           speed_mode/paddle_width/speed_warn/paddle_warn/bonus_ack back out.
interface bonus_effect_ctrl_if;
  logic [2:0] bonus_code;     // one-cycle pulse: 0 none, 1 LONG, 2 SHORT, 3 FAST, 4 SLOW
  logic       startOfFrame;   // one-cycle pulse per video frame
  logic       clear_effects;  // level: hold both channels at NORMAL
  logic [1:0] speed_mode;     // 0 NORMAL, 1 FAST, 2 SLOW
  logic [7:0] paddle_width;   // paddle width in pixels
  logic       speed_warn;     // speed effect close to expiry
  logic       paddle_warn;    // paddle effect close to expiry
  logic       bonus_ack;      // one-cycle pulse when a code 1..4 is accepted

  // Game logic side: drives codes and frame ticks, consumes effects.
  modport master (
    output bonus_code, startOfFrame, clear_effects,
    input  speed_mode, paddle_width, speed_warn, paddle_warn, bonus_ack
  );

  // Controller side.
  modport slave (
    input  bonus_code, startOfFrame, clear_effects,
    output speed_mode, paddle_width, speed_warn, paddle_warn, bonus_ack
  );
endinterface

// File: rtl/bonus_effect_ctrl.sv
// Purpose : turns bonus code pulses into timed speed/paddle effects with expiry warnings.
// Ports   : clk, resetN (sync active-low), bus (slave modport of bonus_effect_ctrl_if).
// Latency : one clock from sampled code to new outputs and bonus_ack; no backpressure.
module bonus_effect_ctrl #(
  parameter int DURATION_FRAMES = 600,
  parameter int WARN_FRAMES     = 120,
  parameter int TIMER_BITS      = 10,
  parameter int NORMAL_W        = 64,
  parameter int SHORT_W         = 32,
  parameter int LONG_W          = 112
) (
  input  logic                 clk,
  input  logic                 resetN,
  bonus_effect_ctrl_if.slave   bus
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  typedef enum logic {EFF_FAST, EFF_SLOW} spd_eff_t;
  typedef enum logic {EFF_SHORT, EFF_LONG} pad_eff_t;

  localparam logic [TIMER_BITS-1:0] LP_DUR  = TIMER_BITS'(DURATION_FRAMES);
  localparam logic [TIMER_BITS-1:0] LP_WARN = TIMER_BITS'(WARN_FRAMES);
  localparam logic [TIMER_BITS-1:0] LP_ONE  = TIMER_BITS'(1);
  localparam logic [7:0]            LP_NORMAL_W = 8'(NORMAL_W);
  localparam logic [7:0]            LP_SHORT_W  = 8'(SHORT_W);
  localparam logic [7:0]            LP_LONG_W   = 8'(LONG_W);

  // Channel state
  state_t                r_spd_state;
  spd_eff_t              r_spd_eff;
  logic [TIMER_BITS-1:0] r_spd_tmr;
  state_t                r_pad_state;
  pad_eff_t              r_pad_eff;
  logic [TIMER_BITS-1:0] r_pad_tmr;

  // Registered outputs
  logic [1:0] r_speed_mode;
  logic [7:0] r_paddle_width;
  logic       r_speed_warn;
  logic       r_paddle_warn;
  logic       r_bonus_ack;

  // Code decode; clear_effects masks every load so dropped codes are never acked.
  logic w_spd_load;
  logic w_pad_load;
  spd_eff_t w_spd_new_eff;
  pad_eff_t w_pad_new_eff;

  always_comb begin
    w_spd_load    = 1'b0;
    w_pad_load    = 1'b0;
    w_spd_new_eff = EFF_FAST;
    w_pad_new_eff = EFF_LONG;
    if (!bus.clear_effects) begin
      case (bus.bonus_code)
        3'd1: begin w_pad_load = 1'b1; w_pad_new_eff = EFF_LONG;  end
        3'd2: begin w_pad_load = 1'b1; w_pad_new_eff = EFF_SHORT; end
        3'd3: begin w_spd_load = 1'b1; w_spd_new_eff = EFF_FAST;  end
        3'd4: begin w_spd_load = 1'b1; w_spd_new_eff = EFF_SLOW;  end
        default: ;
      endcase
    end
  end

  // Next-state for the speed channel. Priority: clear > load > frame countdown.
  // A load in the same cycle as a frame tick restarts at full duration.
  state_t                w_spd_nxt_state;
  spd_eff_t              w_spd_nxt_eff;
  logic [TIMER_BITS-1:0] w_spd_nxt_tmr;

  always_comb begin
    w_spd_nxt_state = r_spd_state;
    w_spd_nxt_eff   = r_spd_eff;
    w_spd_nxt_tmr   = r_spd_tmr;
    if (bus.clear_effects) begin
      w_spd_nxt_state = ST_IDLE;
      w_spd_nxt_tmr   = '0;
    end else if (w_spd_load) begin
      w_spd_nxt_state = ST_ACTIVE;
      w_spd_nxt_eff   = w_spd_new_eff;
      w_spd_nxt_tmr   = LP_DUR;
    end else if (r_spd_state == ST_ACTIVE && bus.startOfFrame) begin
      // Expire on the tick that takes the timer from 1 to 0.
      if (r_spd_tmr <= LP_ONE) begin
        w_spd_nxt_state = ST_IDLE;
        w_spd_nxt_tmr   = '0;
      end else begin
        w_spd_nxt_tmr   = r_spd_tmr - LP_ONE;
      end
    end
  end

  // Next-state for the paddle channel, same structure as speed.
  state_t                w_pad_nxt_state;
  pad_eff_t              w_pad_nxt_eff;
  logic [TIMER_BITS-1:0] w_pad_nxt_tmr;

  always_comb begin
    w_pad_nxt_state = r_pad_state;
    w_pad_nxt_eff   = r_pad_eff;
    w_pad_nxt_tmr   = r_pad_tmr;
    if (bus.clear_effects) begin
      w_pad_nxt_state = ST_IDLE;
      w_pad_nxt_tmr   = '0;
    end else if (w_pad_load) begin
      w_pad_nxt_state = ST_ACTIVE;
      w_pad_nxt_eff   = w_pad_new_eff;
      w_pad_nxt_tmr   = LP_DUR;
    end else if (r_pad_state == ST_ACTIVE && bus.startOfFrame) begin
      if (r_pad_tmr <= LP_ONE) begin
        w_pad_nxt_state = ST_IDLE;
        w_pad_nxt_tmr   = '0;
      end else begin
        w_pad_nxt_tmr   = r_pad_tmr - LP_ONE;
      end
    end
  end

  // Output mapping from next state, so outputs land on the same edge as the state.
  logic [1:0] w_speed_mode;
  logic [7:0] w_paddle_width;
  logic       w_speed_warn;
  logic       w_paddle_warn;

  always_comb begin
    w_speed_mode   = 2'd0;
    w_paddle_width = LP_NORMAL_W;
    if (w_spd_nxt_state == ST_ACTIVE)
      w_speed_mode = (w_spd_nxt_eff == EFF_SLOW) ? 2'd2 : 2'd1;
    if (w_pad_nxt_state == ST_ACTIVE)
      w_paddle_width = (w_pad_nxt_eff == EFF_LONG) ? LP_LONG_W : LP_SHORT_W;
    w_speed_warn  = (w_spd_nxt_state == ST_ACTIVE) && (w_spd_nxt_tmr <= LP_WARN);
    w_paddle_warn = (w_pad_nxt_state == ST_ACTIVE) && (w_pad_nxt_tmr <= LP_WARN);
  end

  // Both channel FSMs and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_spd_state    <= ST_IDLE;
      r_spd_eff      <= EFF_FAST;
      r_spd_tmr      <= '0;
      r_pad_state    <= ST_IDLE;
      r_pad_eff      <= EFF_LONG;
      r_pad_tmr      <= '0;
      r_speed_mode   <= 2'd0;
      r_paddle_width <= LP_NORMAL_W;
      r_speed_warn   <= 1'b0;
      r_paddle_warn  <= 1'b0;
      r_bonus_ack    <= 1'b0;
    end else begin
      r_spd_state    <= w_spd_nxt_state;
      r_spd_eff      <= w_spd_nxt_eff;
      r_spd_tmr      <= w_spd_nxt_tmr;
      r_pad_state    <= w_pad_nxt_state;
      r_pad_eff      <= w_pad_nxt_eff;
      r_pad_tmr      <= w_pad_nxt_tmr;
      r_speed_mode   <= w_speed_mode;
      r_paddle_width <= w_paddle_width;
      r_speed_warn   <= w_speed_warn;
      r_paddle_warn  <= w_paddle_warn;
      r_bonus_ack    <= w_spd_load | w_pad_load;
    end
  end

  assign bus.speed_mode   = r_speed_mode;
  assign bus.paddle_width = r_paddle_width;
  assign bus.speed_warn   = r_speed_warn;
  assign bus.paddle_warn  = r_paddle_warn;
  assign bus.bonus_ack    = r_bonus_ack;

endmodule

// File: doc/bonus_effect_ctrl.md
Name: bonus_effect_ctrl

Overview:
- Consumes the one-cycle bonus code pulse from the random bonus picker (driven on a brick hit) and turns it into timed game effects.
- Maintains two independent effect channels:
  - speed: NORMAL / FAST / SLOW, consumed by the ball mover;
  - paddle: NORMAL / SHORT / LONG, consumed by the paddle drawer and collision logic.
- Each active effect expires after a fixed number of frames. A warning flag is raised near expiry so the display can blink the bonus icon.

Parameters:
- DURATION_FRAMES, 600, frames an effect stays active after being granted (10 s at 60 Hz); must be >= 1
- WARN_FRAMES, 120, warning window length in frames; warn is asserted while 0 < remaining <= WARN_FRAMES
- TIMER_BITS, 10, width of each frame countdown; must satisfy 2^TIMER_BITS > DURATION_FRAMES
- NORMAL_W, 64, normal paddle width in pixels
- SHORT_W, 32, paddle width in pixels during SHORT
- LONG_W, 112, paddle width in pixels during LONG

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset, sampled on the rising edge of clk
- bonus_code  in  3  one-cycle bonus pulse; 0 = none, 1 = LONG, 2 = SHORT, 3 = FAST, 4 = SLOW, 5..7 = reserved
- startOfFrame  in  1  one-cycle pulse once per video frame
- clear_effects  in  1  level; while high, forces both channels back to NORMAL (used on life lost / level start)
- speed_mode  out  2  0 = NORMAL, 1 = FAST, 2 = SLOW
- paddle_width  out  8  current paddle width in pixels
- speed_warn  out  1  speed effect is inside its warning window
- paddle_warn  out  1  paddle effect is inside its warning window
- bonus_ack  out  1  one-cycle pulse when a valid code (1..4) is accepted

Behaviour:
- All outputs are registered and update on the rising edge of clk.
- Reset (resetN = 0 at a clock edge):
  - speed_mode = 0, paddle_width = NORMAL_W;
  - both timers = 0, both channel FSMs go to IDLE;
  - speed_warn = 0, paddle_warn = 0, bonus_ack = 0;
  - reset mid-effect cancels the effect with no residual timer.
- Each channel has a 2-state FSM: IDLE and ACTIVE, with an effect register and a TIMER_BITS down-counter.
  - Speed channel effect register: FAST or SLOW.
  - Paddle channel effect register: SHORT or LONG.
- Accepting a code:
  - bonus_code 1 or 2 → paddle channel; 3 or 4 → speed channel.
  - On the edge where the code is sampled:
    - the channel goes to ACTIVE;
    - the effect register is loaded with the new effect;
    - the timer is loaded with DURATION_FRAMES.
  - The outputs reflect the new effect one clock after the sampled edge; bonus_ack is high in that same cycle.
  - A code arriving while the channel is ACTIVE replaces the effect and restarts the timer at full duration. This holds for both the same effect and the opposite effect (e.g. SLOW arriving during FAST → SLOW, timer = DURATION_FRAMES). There is no stacking.
  - Codes 0 and 5..7: no state change, bonus_ack stays 0.
- Countdown:
  - On each startOfFrame while ACTIVE, the timer decrements by 1.
  - When a startOfFrame arrives with timer = 1, the timer becomes 0, the FSM goes to IDLE and the output returns to NORMAL on that edge.
  - startOfFrame while IDLE has no effect; the timer never wraps below 0.
- Simultaneous events:
  - Accepted code and startOfFrame in the same cycle on the same channel: the load wins (timer = DURATION_FRAMES, not DURATION_FRAMES - 1).
  - A code on one channel does not disturb the other channel's timer, which still counts that frame.
- clear_effects:
  - Highest priority below reset: while it is high, both channels are held IDLE, timers = 0, outputs NORMAL, warns = 0.
  - Codes arriving during clear are dropped and bonus_ack = 0.
- Warning flags:
  - x_warn = ACTIVE and timer <= WARN_FRAMES, registered from the next-state timer.
  - The flag deasserts on the same edge the channel expires.
- Output mapping:
  - speed_mode follows the speed effect: IDLE → 0, FAST → 1, SLOW → 2.
  - paddle_width: IDLE → NORMAL_W, SHORT → SHORT_W, LONG → LONG_W.

Test Plan (DURATION_FRAMES = 5, WARN_FRAMES = 2 override):
- Reset, then bonus_code = 3 for 1 cycle → next cycle speed_mode = 1 and bonus_ack = 1. After 3 startOfFrame pulses speed_warn = 1. On the 5th startOfFrame speed_mode = 0 and speed_warn = 0.
- bonus_code = 1, then 3 frames later bonus_code = 2 → paddle_width goes 112 → 32, and 32 is held for 5 more frames before returning to 64.
- bonus_code = 4 and startOfFrame in the same cycle → speed_mode = 2, timer = 5; exactly 5 further frames are needed to expire.
- Paddle LONG active, then bonus_code = 3 → speed_mode = 1, and the paddle timer keeps counting unaffected (paddle expires at its original frame).
- bonus_code = 6, then bonus_code = 0 → no output change, bonus_ack never asserts.
- Both channels active; pulse clear_effects for 1 cycle with a simultaneous bonus_code = 2 → speed_mode = 0, paddle_width = 64, no ack. Repeat with resetN = 0 mid-effect → all outputs at reset values.
